// File: rtl/vedic_mult_pipe.sv
// Parametrised 4-stage Vedic multiplier: four half-width sub-products recombined,
// with per-beat signed/unsigned mode, valid/ready handshake with full stall, and a tag.
module vedic_mult_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int H   = WIDTH / 2;
    localparam int PRW = 2 * H;
    localparam int MW  = 2 * H + 2;
    localparam int PW  = 2 * WIDTH;

    logic adv;

    // stage 1 registers
    logic               s1_v;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic               s1_neg;
    logic [TAG_W-1:0]   s1_tag;

    // stage 2 registers
    logic               s2_v;
    logic [PRW-1:0]     s2_ll;
    logic [PRW-1:0]     s2_hl;
    logic [PRW-1:0]     s2_lh;
    logic [PRW-1:0]     s2_hh;
    logic               s2_neg;
    logic [TAG_W-1:0]   s2_tag;

    // stage 3 registers
    logic               s3_v;
    logic [MW-1:0]      s3_mid;
    logic [H-1:0]       s3_ll_lo;
    logic [PRW-1:0]     s3_hh;
    logic               s3_neg;
    logic [TAG_W-1:0]   s3_tag;

    // combinational stage inputs
    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic               neg_c;
    logic [PRW-1:0]     ll_c;
    logic [PRW-1:0]     hl_c;
    logic [PRW-1:0]     lh_c;
    logic [PRW-1:0]     hh_c;
    logic [MW-1:0]      mid_c;
    logic [PW-1:0]      mag_c;
    logic [PW-1:0]      result_c;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign busy     = s1_v | s2_v | s3_v | out_valid;

    // Two's-complement negate of the most negative value wraps back to 2^(WIDTH-1),
    // which is exactly its magnitude as an unsigned number.
    always_comb begin
        neg_c   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        mag_a_c = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b_c = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;
    end

    always_comb begin
        ll_c = PRW'(s1_a[H-1:0])     * PRW'(s1_b[H-1:0]);
        hl_c = PRW'(s1_a[WIDTH-1:H]) * PRW'(s1_b[H-1:0]);
        lh_c = PRW'(s1_a[H-1:0])     * PRW'(s1_b[WIDTH-1:H]);
        hh_c = PRW'(s1_a[WIDTH-1:H]) * PRW'(s1_b[WIDTH-1:H]);
    end

    always_comb begin
        mid_c = MW'(s2_hl) + MW'(s2_lh) + MW'(s2_ll[PRW-1:H]);
    end

    always_comb begin
        mag_c    = (PW'(s3_hh) << (2 * H)) + (PW'(s3_mid) << H) + PW'(s3_ll_lo);
        result_c = s3_neg ? -mag_c : mag_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_neg <= 1'b0;
            s1_tag <= '0;
        end else if (adv) begin
            s1_v   <= in_valid;
            s1_a   <= mag_a_c;
            s1_b   <= mag_b_c;
            s1_neg <= neg_c;
            s1_tag <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_v   <= 1'b0;
            s2_ll  <= '0;
            s2_hl  <= '0;
            s2_lh  <= '0;
            s2_hh  <= '0;
            s2_neg <= 1'b0;
            s2_tag <= '0;
        end else if (adv) begin
            s2_v   <= s1_v;
            s2_ll  <= ll_c;
            s2_hl  <= hl_c;
            s2_lh  <= lh_c;
            s2_hh  <= hh_c;
            s2_neg <= s1_neg;
            s2_tag <= s1_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_v     <= 1'b0;
            s3_mid   <= '0;
            s3_ll_lo <= '0;
            s3_hh    <= '0;
            s3_neg   <= 1'b0;
            s3_tag   <= '0;
        end else if (adv) begin
            s3_v     <= s2_v;
            s3_mid   <= mid_c;
            s3_ll_lo <= s2_ll[H-1:0];
            s3_hh    <= s2_hh;
            s3_neg   <= s2_neg;
            s3_tag   <= s2_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (adv) begin
            out_valid  <= s3_v;
            out_result <= result_c;
            out_tag    <= s3_tag;
        end
    end

endmodule

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised successor to the fixed 32x32 Vedic multiplier.
- Multiplies two WIDTH-bit operands through a fixed-latency, 4-stage pipeline built from four half-width sub-products.
- Adds per-transaction signed/unsigned mode, a valid/ready handshake with full-pipeline stall, and a sideband tag.
- Sits between operand fetch and the accumulation stage of the matrix multiplier.

Parameters:
- WIDTH, 32, operand width; even, >= 4.
- TAG_W, 4, sideband tag width carried alongside each product.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts operand beat this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  2*WIDTH  product, signed or unsigned per in_signed of that beat.
- out_tag  out  TAG_W  tag of that beat.
- busy  out  1  any pipeline stage holds a valid beat.

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits 0; out_valid=0, busy=0, out_result=0, out_tag=0. Stage data registers also clear to 0.
- Advance: adv = out_ready | ~out_valid. in_ready = adv (combinational). When adv=0, every stage holds its contents.
- Accept: a beat is accepted when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 1. Bubbles do not collapse.
- Latency: exactly 4 cycles of advancement from acceptance to out_valid. Throughput is 1 beat/cycle when out_ready is held high.
- S1: register operands, tag and mode.
  - Signed mode: convert each operand to a WIDTH-bit unsigned magnitude (the most negative value maps to 2^(WIDTH-1)). Record neg = sign_a ^ sign_b.
  - Unsigned mode: neg=0; operands pass unchanged.
- S2: H=WIDTH/2. Register four H x H unsigned products of the magnitudes: ll=aL*bL, hl=aH*bL, lh=aL*bH, hh=aH*bH, each 2H bits.
- S3: mid = hl + lh + ll[2H-1:H], width 2H+2, no truncation. Carry ll[H-1:0] and hh forward.
- S4: mag = {hh,0..}(shifted by 2H) + {mid,0..}(shifted by H) + ll[H-1:0], width 2*WIDTH, no overflow.
  - out_result = neg ? (~mag+1) : mag.
  - Zero product with neg=1 yields 0.
- Outputs are registered. out_result and out_tag are held stable while out_valid=1 and out_ready=0.
- busy = OR of the 4 stage valid bits.
- Reset asserted mid-operation discards all in-flight beats immediately. No partial output is ever presented.
- Simultaneous output pop and input push in the same cycle with a full pipeline is legal; no beat is lost or duplicated.

Test Plan:
- Unsigned max: WIDTH=32, a=b=0xFFFFFFFF, signed=0, tag=3 -> after 4 cycles out_result=0xFFFFFFFE00000001, out_tag=3.
- Signed: a=b=0xFFFFFFFF, signed=1 -> 0x0000000000000001. Then a=0x80000000, b=0x80000000, signed=1 -> 0x4000000000000000. Then a=0x80000000, b=1, signed=1 -> 0xFFFFFFFF80000000.
- Streaming: 16 back-to-back random beats, out_ready=1 -> 16 results in order at 1/cycle, matching the reference model, tags 0..15 in sequence.
- Backpressure: fill the pipeline, drop out_ready for 5 cycles -> in_ready=0, out_result and out_tag stable. Release -> remaining beats emerge in order with no loss or duplication.
- Bubbles: beats at cycles 0, 2, 3 -> out_valid pattern 1,0,1,1 starting at cycle 4.
- Reset mid-flight: 3 beats in flight, pulse reset asynchronously between clock edges -> out_valid=0 and busy=0 immediately; no stale result appears after release. A new beat 7*9 returns 63.
- Parametric: rerun the random stream at WIDTH=8 and WIDTH=16 (unsigned and signed); all results match the reference model.
